// File: rtl/causal_conv_pkg.sv
// Shared sizing and saturation helpers for the causal dilated convolution.
// Latency: none (functions and constants only).
// Backpressure: not applicable.
package causal_conv_pkg;

    // Width of the coefficient tap index port.
    localparam int H_INDEX_W = 4;

    // The accumulator needs enough headroom that the full sum of products cannot wrap.
    function automatic int acc_width(input int data_w, input int coef_w, input int kernel_size);
        return data_w + coef_w + $clog2(kernel_size);
    endfunction

    function automatic logic signed [63:0] sat_max(input int data_w);
        return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int data_w);
        return -(64'sd1 <<< (data_w - 1));
    endfunction

    // The caller keeps the low data_w bits of the result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] acc, input int data_w);
        if (acc >= sat_max(data_w))
            return sat_max(data_w);
        else if (acc <= sat_min(data_w))
            return sat_min(data_w);
        else
            return acc;
    endfunction

    // A value equal to a rail is representable, so it does not count as clipped.
    function automatic logic is_clipped(input logic signed [63:0] acc, input int data_w);
        return (acc > sat_max(data_w)) || (acc < sat_min(data_w));
    endfunction

endpackage

// File: rtl/conv_delay_line.sv
// Sample history shift register; taps[0] is din itself, taps[k] is the sample k*DILATION shifts ago.
// Latency: taps[0] combinational, history advances one position per shift.
// Backpressure: none; shifts only when shift is high, clear zeroes the line.
// Ports: clk/reset (async, active-high), shift, clear (sync), din, taps.
module conv_delay_line #(
    parameter int DATA_W      = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int DILATION    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               shift,
    input  logic                               clear,
    input  logic [DATA_W-1:0]                  din,
    output logic [KERNEL_SIZE-1:0][DATA_W-1:0] taps
);

    localparam int LEN      = (KERNEL_SIZE - 1) * DILATION;
    // A one-tap kernel has no history; keep a single dummy stage so the array is never empty.
    localparam int LINE_LEN = (LEN > 0) ? LEN : 1;

    logic [LINE_LEN-1:0][DATA_W-1:0] line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line <= '0;
        end else if (clear) begin
            line <= '0;
        end else if (shift) begin
            line[0] <= din;
            for (int i = 1; i < LINE_LEN; i++)
                line[i] <= line[i-1];
        end
    end

    assign taps[0] = din;

    for (genvar k = 1; k < KERNEL_SIZE; k++) begin : g_tap
        assign taps[k] = line[k*DILATION-1];
    end

endmodule

// File: rtl/causal_dilated_conv.sv
// Streaming causal dilated FIR: y[n] = sat((sum h[k]*x[n-k*DILATION]) >>> FRAC_SHIFT).
// Latency: 1 cycle from accept to out_valid; full throughput under continuous flow.
// Backpressure: in_ready = !clear && (!out_valid || out_ready); y is held during a stall.
// Ports: clk, reset (async, active-high), clear (sync flush), in_valid/in_ready/x,
//        out_valid/out_ready/y, h_write/h_index/h_value (coefficient writes).
// Optional: define SAT_FLAG_EN to add sat_flag, registered with y, high when y was clipped.
module causal_dilated_conv
    import causal_conv_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int COEF_W      = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int DILATION    = 2,
    parameter int FRAC_SHIFT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    y,
`ifdef SAT_FLAG_EN
    output logic                 sat_flag,
`endif
    input  logic                 h_write,
    input  logic [H_INDEX_W-1:0] h_index,
    input  logic [COEF_W-1:0]    h_value
);

    localparam int ACC_W  = acc_width(DATA_W, COEF_W, KERNEL_SIZE);
    localparam int PROD_W = DATA_W + COEF_W;

    logic                               accept;
    logic [KERNEL_SIZE-1:0][DATA_W-1:0] taps;
    logic [KERNEL_SIZE-1:0][COEF_W-1:0] h;
    logic signed [PROD_W-1:0]           prod;
    logic signed [ACC_W-1:0]            acc;
    logic signed [ACC_W-1:0]            acc_sh;
    logic signed [63:0]                 acc_wide;
    logic [DATA_W-1:0]                  y_next;

    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    conv_delay_line #(
        .DATA_W      (DATA_W),
        .KERNEL_SIZE (KERNEL_SIZE),
        .DILATION    (DILATION)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .shift (accept),
        .clear (clear),
        .din   (x),
        .taps  (taps)
    );

    // Coefficients are registers, so an accept in the same cycle as a write sees the old value.
    // Out-of-range indices match no tap and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                h[k] <= COEF_W'(k + 1);
        end else if (h_write) begin
            for (int k = 0; k < KERNEL_SIZE; k++)
                if (h_index == H_INDEX_W'(k))
                    h[k] <= h_value;
        end
    end

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            prod = PROD_W'($signed(taps[k])) * PROD_W'($signed(h[k]));
            acc  = acc + ACC_W'(prod);
        end
        acc_sh   = acc >>> FRAC_SHIFT;
        acc_wide = 64'(acc_sh);
        y_next   = DATA_W'(saturate(acc_wide, DATA_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            y         <= y_next;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SAT_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_flag <= 1'b0;
        else if (clear)
            sat_flag <= 1'b0;
        else if (accept)
            sat_flag <= is_clipped(acc_wide, DATA_W);
    end
`endif

endmodule

// File: tb/tb_causal_dilated_conv.sv
module tb_causal_dilated_conv;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int K  = 3;
    localparam int D  = 2;
    localparam int FS = 0;
    localparam int L  = (K - 1) * D;

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, in_ready, out_valid, out_ready, h_write;
    logic [DW-1:0] x, y;
    logic [3:0]    h_index;
    logic [CW-1:0] h_value;

    logic          in_valid2, in_ready2, out_valid2;
    logic [DW-1:0] x2, y2;
`ifdef SAT_FLAG_EN
    logic          sat_flag, sat_flag2;
`endif

    always #5 clk = ~clk;

    causal_dilated_conv #(
        .DATA_W(DW), .COEF_W(CW), .KERNEL_SIZE(K), .DILATION(D), .FRAC_SHIFT(FS)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
`ifdef SAT_FLAG_EN
        .sat_flag(sat_flag),
`endif
        .h_write(h_write), .h_index(h_index), .h_value(h_value)
    );

    causal_dilated_conv #(
        .DATA_W(DW), .COEF_W(CW), .KERNEL_SIZE(3), .DILATION(1), .FRAC_SHIFT(1)
    ) dut2 (
        .clk(clk), .reset(reset), .clear(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .x(x2),
        .out_valid(out_valid2), .out_ready(1'b1), .y(y2),
`ifdef SAT_FLAG_EN
        .sat_flag(sat_flag2),
`endif
        .h_write(1'b0), .h_index(4'd0), .h_value(8'd0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: coefficients, accepted samples (newest first), pending output.
    int h_m[K];
    int hist[$];
    bit exp_valid;
    int exp_y;
    bit exp_sat;
    int got[$];
    int e[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < K; k++) h_m[k] = k + 1;
        hist.delete();
        exp_valid = 1'b0;
        exp_y     = 0;
        exp_sat   = 1'b0;
    endtask

    task automatic model_accept(input int xs);
        int acc;
        int s;
        acc = 0;
        for (int k = 0; k < K; k++) begin
            if (k == 0)
                s = xs;
            else if (k * D - 1 < hist.size())
                s = hist[k*D-1];
            else
                s = 0;
            acc += h_m[k] * s;
        end
        acc     = acc >>> FS;
        exp_sat = (acc > 127) || (acc < -128);
        exp_y   = (acc >= 127) ? 127 : (acc <= -128) ? -128 : acc;
        exp_valid = 1'b1;
        hist.push_front(xs);
        if (hist.size() > L) void'(hist.pop_back());
    endtask

    // One clock: drive at negedge, predict, check the registered outputs at the next negedge.
    task automatic cyc(input bit v, input int xv, input bit ordy, input bit clr,
                       input bit hw, input int hi, input int hv);
        bit m_ready;
        bit acc;
        in_valid  = v;
        x         = xv[DW-1:0];
        out_ready = ordy;
        clear     = clr;
        h_write   = hw;
        h_index   = hi[3:0];
        h_value   = hv[CW-1:0];
        #1;
        m_ready = !clr && (!exp_valid || ordy);
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        if (out_valid && ordy) got.push_back(int'($signed(y)));
        acc = v && m_ready;
        if (clr) begin
            hist.delete();
            exp_valid = 1'b0;
            exp_y     = 0;
            exp_sat   = 1'b0;
        end else if (acc) begin
            model_accept(int'($signed(x)));
        end else if (exp_valid && ordy) begin
            exp_valid = 1'b0;
        end
        if (hw && hi < K) h_m[hi] = int'($signed(h_value));
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("y", 32'($signed(y)), exp_y);
`ifdef SAT_FLAG_EN
        chk("sat_flag", 32'(sat_flag), 32'(exp_sat));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic do_clear();
        cyc(0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic feed(input int xv, input int n);
        for (int i = 0; i < n; i++) cyc(1, xv, 1, 0, 0, 0, 0);
        idle(1);
    endtask

    task automatic impulse(input int n);
        cyc(1, 1, 1, 0, 0, 0, 0);
        feed(0, n - 1);
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, 32'(got.size() >= e.size()), 32'd1);
        for (int i = 0; i < e.size(); i++)
            if (i < got.size()) chk(tag, got[i], e[i]);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; h_write = 1'b0; h_index = '0; h_value = '0;
        in_valid2 = 1'b0; x2 = '0;
        model_reset();

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'($signed(y)), 32'sd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // Impulse response with default taps 1,2,3 spaced by 2
        got.delete(); impulse(8);
        e = '{1, 0, 2, 0, 3, 0, 0, 0}; cmp_seq("impulse");

        // Saturation at both rails
        do_clear(); got.delete(); feed(100, 6);
        e = '{100, 100, 127, 127, 127, 127}; cmp_seq("sat_pos");
        do_clear(); got.delete(); feed(-100, 6);
        e = '{-100, -100, -128, -128, -128, -128}; cmp_seq("sat_neg");

        // Backpressure: hold the first output for three cycles
        do_clear(); got.delete();
        cyc(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        feed(0, 6);
        e = '{1, 0, 2, 0, 3, 0}; cmp_seq("backpressure");

        // Irregular input gaps must not change the sequence
        do_clear(); got.delete();
        begin
            int n_acc = 0;
            for (int i = 0; i < 60 && n_acc < 7; i++) begin
                bit v = ($urandom_range(0, 2) != 0);
                cyc(v, (n_acc == 0) ? 1 : 0, 1, 0, 0, 0, 0);
                if (v) n_acc++;
            end
        end
        idle(1);
        e = '{1, 0, 2, 0, 3, 0, 0}; cmp_seq("gaps");

        // Coefficient writes, including an ignored out-of-range index
        do_clear(); got.delete();
        cyc(0, 0, 1, 0, 1, 1, 255);
        cyc(0, 0, 1, 0, 1, 3, 9);
        impulse(6);
        e = '{1, 0, -1, 0, 3, 0}; cmp_seq("coef_write");

        // Write coincident with accept applies from the next sample
        do_clear(); got.delete();
        cyc(1, 1, 1, 0, 1, 0, 5);
        cyc(1, 1, 1, 0, 0, 0, 0);
        idle(1);
        e = '{1, 5}; cmp_seq("coef_coincident");

        // clear flushes history; coefficients restored by writes during the stream
        do_clear();
        cyc(1, 5, 1, 0, 1, 0, 1);
        cyc(1, 5, 1, 0, 1, 1, 2);
        cyc(1, 5, 1, 1, 0, 0, 0);
        got.delete(); impulse(6);
        e = '{1, 0, 2, 0, 3, 0}; cmp_seq("after_clear");

        // Asynchronous reset during a stall, with a modified coefficient
        cyc(0, 0, 1, 0, 1, 0, 9);
        cyc(1, 7, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_y", 32'($signed(y)), 32'sd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        got.delete(); impulse(6);
        e = '{1, 0, 2, 0, 3, 0}; cmp_seq("after_reset");

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) == 0, int'($urandom_range(0, 4)),
                int'($urandom_range(0, 255)));

        // Second instance: FRAC_SHIFT=1, DILATION=1, constant x=3
        got.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1;
            x2 = 8'd3;
            @(negedge clk);
            if (out_valid2) got.push_back(int'($signed(y2)));
`ifdef SAT_FLAG_EN
            chk("sat_flag2", 32'(sat_flag2), 32'd0);
`endif
        end
        in_valid2 = 1'b0;
        e = '{1, 4, 9, 9, 9}; cmp_seq("frac_shift");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
